athena_pixel_shifter: RTL and testbench

Background/sprite pixel serializer that sits directly downstream of the Athena A6001-1 timing PAL. It consumes the PAL's PLOAD_RSHIFTn, RL_Sel, AB_Sel, VDG and G15_CE strobes. It fetches 32-bit tile-row words (8 pixels × 4 bpp) through a simple ROM request/ack port into a two-bank holding buffer. It parallel-loads the active bank into a nibble shift register and emits one registered 8-bit pixel per pixel-clock edge.

---
 rtl/athena_pkg.sv | 25 ++
 rtl/athena_pixel_shifter_if.sv | 32 +++
 rtl/athena_cen_edge.sv | 31 +++
 rtl/athena_pixel_shifter.sv | 157 +++++++++++++++
 tb/tb_athena_pixel_shifter.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/athena_pkg.sv
// Shared types and widths for the Athena pixel serializer.
//   PIXW   - bits per pixel (ROM word holds NPIX pixels)
//   ATTRW  - palette attribute width
//   COLW   - column counter / ROM address width
//   bank_t - one holding-buffer entry {valid, data, attr}
package athena_pkg;

    localparam int unsigned PIXW  = 4;
    localparam int unsigned ATTRW = 4;
    localparam int unsigned COLW  = 6;
    localparam int unsigned NPIX  = 8;
    localparam int unsigned WORDW = PIXW * NPIX;

    typedef struct packed {
        logic             valid;
        logic [31:0]      data;
        logic [ATTRW-1:0] attr;
    } bank_t;

    typedef enum logic {
        StIdle,
        StReq
    } req_state_e;

endpackage

// File: rtl/athena_pixel_shifter_if.sv
// ROM fetch port of the pixel serializer.
//   rom_addr - column being fetched       (master -> slave)
//   rom_req  - fetch request level        (master -> slave)
//   rom_ack  - one-cycle acknowledge      (slave -> master)
//   rom_data - 8 packed 4-bit pixels      (slave -> master, valid with ack)
//   rom_attr - attribute for the word     (slave -> master, valid with ack)
interface athena_pixel_shifter_if;
    import athena_pkg::*;

    logic [COLW-1:0]  rom_addr;
    logic             rom_req;
    logic             rom_ack;
    logic [31:0]      rom_data;
    logic [ATTRW-1:0] rom_attr;

    modport master (
        output rom_addr,
        output rom_req,
        input  rom_ack,
        input  rom_data,
        input  rom_attr
    );

    modport slave (
        input  rom_addr,
        input  rom_req,
        output rom_ack,
        output rom_data,
        output rom_attr
    );

endinterface

// File: rtl/athena_cen_edge.sv
// Rising-edge detector for a clock-enable level.
//   clk     - system clock
//   Reset_n - synchronous active-low reset
//   cen_i   - enable level
//   ce_o    - one-clk pulse in the cycle cen_i is high after being low
// The history bit resets to 1 so an enable already high at reset release
// does not produce a spurious pulse.
module athena_cen_edge (
    input  logic clk,
    input  logic Reset_n,
    input  logic cen_i,
    output logic ce_o
);

    logic last_cen_q, last_cen_d;

    always_comb begin
        last_cen_d = cen_i;
    end

    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            last_cen_q <= 1'b1;
        end else begin
            last_cen_q <= last_cen_d;
        end
    end

    assign ce_o = cen_i & ~last_cen_q;

endmodule

// File: rtl/athena_pixel_shifter.sv
// Background/sprite pixel serializer.
//   clk, Reset_n   - system clock, synchronous active-low reset
//   Cen            - pixel clock-enable level (advance on its rising edge)
//   PLOAD_RSHIFTn  - 0: load shifter from bank AB_Sel, 1: shift
//   RL_Sel         - 1: LSB nibble first, 0: MSB nibble first
//   AB_Sel         - displayed bank; ROM fills go to the other bank
//   VDG            - blank output
//   G15_CE         - column advance enable
//   rom            - ROM fetch port (master side)
//   pix            - registered {attr, pixel}
//   pix_opaque     - registered: pixel nibble nonzero and not blanked
//   underrun       - sticky: load from an empty bank
//   overrun        - sticky: fill into a full bank, or advance with a fetch pending
module athena_pixel_shifter
    import athena_pkg::*;
(
    input  logic                     clk,
    input  logic                     Reset_n,
    input  logic                     Cen,
    input  logic                     PLOAD_RSHIFTn,
    input  logic                     RL_Sel,
    input  logic                     AB_Sel,
    input  logic                     VDG,
    input  logic                     G15_CE,
    athena_pixel_shifter_if.master   rom,
    output logic [ATTRW+PIXW-1:0]    pix,
    output logic                     pix_opaque,
    output logic                     underrun,
    output logic                     overrun
);

    logic ce;
    logic inc;
    logic fill_sel;
    logic load_sel;
    logic [PIXW-1:0] out_nib;

    bank_t                 bank_q [2];
    bank_t                 bank_d [2];
    logic [WORDW-1:0]      sr_q, sr_d;
    logic [ATTRW-1:0]      attr_q, attr_d;
    logic [COLW-1:0]       col_q, col_d;
    req_state_e            req_state_q, req_state_d;
    logic [ATTRW+PIXW-1:0] pix_q, pix_d;
    logic                  opaque_q, opaque_d;
    logic                  underrun_q, underrun_d;
    logic                  overrun_q, overrun_d;

    athena_cen_edge u_cen_edge (
        .clk     (clk),
        .Reset_n (Reset_n),
        .cen_i   (Cen),
        .ce_o    (ce)
    );

    assign inc      = ce & G15_CE;
    assign fill_sel = ~AB_Sel;
    assign load_sel = AB_Sel;
    assign out_nib  = RL_Sel ? sr_q[PIXW-1:0] : sr_q[WORDW-1 -: PIXW];

    always_comb begin
        bank_d      = bank_q;
        sr_d        = sr_q;
        attr_d      = attr_q;
        col_d       = col_q;
        req_state_d = req_state_q;
        pix_d       = pix_q;
        opaque_d    = opaque_q;
        underrun_d  = underrun_q;
        overrun_d   = overrun_q;

        if (inc) begin
            col_d = col_q + 1'b1;
        end

        // Request FSM: an advance always (re)opens a request for the new column.
        unique case (req_state_q)
            StIdle: begin
                if (inc) begin
                    req_state_d = StReq;
                end
            end
            StReq: begin
                if (inc) begin
                    overrun_d = 1'b1;
                end else if (rom.rom_ack) begin
                    req_state_d = StIdle;
                end
            end
            default: req_state_d = StIdle;
        endcase

        // Fill and load touch complementary banks, so they never collide.
        if (rom.rom_ack) begin
            if (bank_q[fill_sel].valid) begin
                overrun_d = 1'b1;
            end
            bank_d[fill_sel].valid = 1'b1;
            bank_d[fill_sel].data  = rom.rom_data;
            bank_d[fill_sel].attr  = rom.rom_attr;
        end

        if (ce) begin
            // Output uses the pre-load shifter contents.
            pix_d    = VDG ? '0 : {attr_q, out_nib};
            opaque_d = (|out_nib) & ~VDG;
            if (!PLOAD_RSHIFTn) begin
                if (bank_q[load_sel].valid) begin
                    sr_d   = bank_q[load_sel].data;
                    attr_d = bank_q[load_sel].attr;
                end else begin
                    sr_d       = '0;
                    attr_d     = '0;
                    underrun_d = 1'b1;
                end
                bank_d[load_sel].valid = 1'b0;
            end else if (RL_Sel) begin
                sr_d = sr_q >> PIXW;
            end else begin
                sr_d = sr_q << PIXW;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset_n) begin
            bank_q[0]   <= '0;
            bank_q[1]   <= '0;
            sr_q        <= '0;
            attr_q      <= '0;
            col_q       <= '0;
            req_state_q <= StIdle;
            pix_q       <= '0;
            opaque_q    <= 1'b0;
            underrun_q  <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            bank_q      <= bank_d;
            sr_q        <= sr_d;
            attr_q      <= attr_d;
            col_q       <= col_d;
            req_state_q <= req_state_d;
            pix_q       <= pix_d;
            opaque_q    <= opaque_d;
            underrun_q  <= underrun_d;
            overrun_q   <= overrun_d;
        end
    end

    assign rom.rom_addr = col_q;
    assign rom.rom_req  = (req_state_q == StReq);
    assign pix          = pix_q;
    assign pix_opaque   = opaque_q;
    assign underrun     = underrun_q;
    assign overrun      = overrun_q;

endmodule

// File: tb/tb_athena_pixel_shifter.sv
// Self-checking bench for athena_pixel_shifter: directed scenarios followed by
// randomized stimulus, all compared against a nibble-queue reference model.
module tb_athena_pixel_shifter;
    import athena_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n, cen, pload_n, rl_sel, ab_sel, vdg, g15_ce;
    logic [7:0] pix;
    logic       pix_opaque, underrun, overrun;

    athena_pixel_shifter_if rom_if();

    athena_pixel_shifter dut (
        .clk           (clk),
        .Reset_n       (reset_n),
        .Cen           (cen),
        .PLOAD_RSHIFTn (pload_n),
        .RL_Sel        (rl_sel),
        .AB_Sel        (ab_sel),
        .VDG           (vdg),
        .G15_CE        (g15_ce),
        .rom           (rom_if),
        .pix           (pix),
        .pix_opaque    (pix_opaque),
        .underrun      (underrun),
        .overrun       (overrun)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: banks hold pixel lists, the shifter is a queue of
    // pixel values with index 0 the LSB-side pixel.
    bit m_last_cen;
    int m_col;
    bit m_req, m_under, m_over, m_opaque;
    int m_pix;
    bit m_valid [2];
    int m_nib   [2][8];
    int m_battr [2];
    int m_sr [$];
    int m_attr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_last_cen = 1'b1;
        m_col      = 0;
        m_req      = 1'b0;
        m_under    = 1'b0;
        m_over     = 1'b0;
        m_pix      = 0;
        m_opaque   = 1'b0;
        m_valid[0] = 1'b0;
        m_valid[1] = 1'b0;
        m_attr     = 0;
        m_sr.delete();
        for (int i = 0; i < 8; i++) m_sr.push_back(0);
    endfunction

    function automatic void model_clock();
        bit ce, inc, ack;
        int tgt, s, px;
        if (!reset_n) begin
            model_reset();
            return;
        end
        ce = cen && !m_last_cen;
        m_last_cen = cen;
        inc = ce && g15_ce;
        ack = rom_if.rom_ack;
        if (inc && m_req) m_over = 1'b1;
        if (ack) begin
            tgt = ab_sel ? 0 : 1;
            if (m_valid[tgt]) m_over = 1'b1;
            for (int i = 0; i < 8; i++) m_nib[tgt][i] = int'((rom_if.rom_data >> (4 * i)) & 32'hF);
            m_battr[tgt] = int'(rom_if.rom_attr);
            m_valid[tgt] = 1'b1;
        end
        if (inc) m_req = 1'b1;
        else if (ack) m_req = 1'b0;
        if (inc) m_col = (m_col + 1) % 64;
        if (ce) begin
            px = rl_sel ? m_sr[0] : m_sr[7];
            m_pix    = vdg ? 0 : m_attr * 16 + px;
            m_opaque = !vdg && (px != 0);
            if (!pload_n) begin
                s = ab_sel ? 1 : 0;
                m_sr.delete();
                if (m_valid[s]) begin
                    for (int i = 0; i < 8; i++) m_sr.push_back(m_nib[s][i]);
                    m_attr = m_battr[s];
                    m_valid[s] = 1'b0;
                end else begin
                    for (int i = 0; i < 8; i++) m_sr.push_back(0);
                    m_attr  = 0;
                    m_under = 1'b1;
                end
            end else if (rl_sel) begin
                void'(m_sr.pop_front());
                m_sr.push_back(0);
            end else begin
                void'(m_sr.pop_back());
                m_sr.push_front(0);
            end
        end
    endfunction

    task automatic check_outputs();
        check("pix",        pix,             m_pix);
        check("pix_opaque", pix_opaque,      m_opaque);
        check("underrun",   underrun,        m_under);
        check("overrun",    overrun,         m_over);
        check("rom_req",    rom_if.rom_req,  m_req);
        check("rom_addr",   rom_if.rom_addr, m_col);
    endtask

    task automatic step();
        @(posedge clk);
        model_clock();
        #1;
        check_outputs();
    endtask

    task automatic ce_pulse();
        cen = 1'b1;
        step();
        cen = 1'b0;
        step();
    endtask

    task automatic ack_word(input logic [31:0] d, input logic [3:0] a);
        rom_if.rom_ack  = 1'b1;
        rom_if.rom_data = d;
        rom_if.rom_attr = a;
        step();
        rom_if.rom_ack  = 1'b0;
    endtask

    // Fill bank B, load it, then play 8 pixels; vdg_mask bit i blanks pixel i+1.
    task automatic play_word(input logic rl, input logic [7:0] vdg_mask, input string tag);
        int exp_px;
        ab_sel = 1'b0;
        ack_word(32'h8765_4321, 4'hA);
        ab_sel  = 1'b1;
        rl_sel  = rl;
        pload_n = 1'b0;
        ce_pulse();
        pload_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            vdg = vdg_mask[i-1];
            ce_pulse();
            exp_px = rl ? i : 9 - i;
            check({tag, "_pix"}, pix, vdg ? 8'h00 : 8'hA0 + 8'(exp_px));
            check({tag, "_opq"}, pix_opaque, !vdg);
        end
        vdg = 1'b0;
    endtask

    initial begin
        model_reset();
        reset_n = 1'b0;
        cen = 1'b0; pload_n = 1'b1; rl_sel = 1'b1; ab_sel = 1'b0; vdg = 1'b0; g15_ce = 1'b0;
        rom_if.rom_ack = 1'b0; rom_if.rom_data = '0; rom_if.rom_attr = '0;
        step();
        step();
        check("rst_pix", pix, 0);
        check("rst_req", rom_if.rom_req, 0);
        check("rst_addr", rom_if.rom_addr, 0);
        reset_n = 1'b1;
        step();

        play_word(1'b1, 8'h00, "right");
        play_word(1'b0, 8'h00, "left");
        check("no_underrun", underrun, 0);

        // Load from empty bank A.
        ab_sel = 1'b0; pload_n = 1'b0; rl_sel = 1'b1;
        ce_pulse();
        pload_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ce_pulse();
            check("under_pix", pix, 0);
            check("under_flag", underrun, 1);
        end
        play_word(1'b1, 8'h00, "after_under");
        check("under_sticky", underrun, 1);

        play_word(1'b1, 8'h1C, "blank");

        // 64 column advances, each loading B and then refilling B.
        g15_ce = 1'b1; pload_n = 1'b0;
        for (int i = 0; i < 64; i++) begin
            ab_sel = 1'b1;
            cen = 1'b1;
            step();
            check("col_addr", rom_if.rom_addr, (i + 1) % 64);
            check("col_req", rom_if.rom_req, 1);
            cen = 1'b0;
            ab_sel = 1'b0;
            ack_word($urandom, 4'($urandom));
            check("col_req_clr", rom_if.rom_req, 0);
        end
        check("col_wrap", rom_if.rom_addr, 0);
        check("col_no_over", overrun, 0);

        // Two advances without an ack.
        ab_sel = 1'b1;
        ce_pulse();
        ce_pulse();
        check("over_flag", overrun, 1);
        check("over_addr", rom_if.rom_addr, 2);
        check("over_req", rom_if.rom_req, 1);
        ab_sel = 1'b0;
        ack_word(32'h8765_4321, 4'hA);

        // Reset on the 4th pixel with a request pending.
        ab_sel = 1'b1; rl_sel = 1'b1; g15_ce = 1'b0;
        ce_pulse();
        pload_n = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            ce_pulse();
            check("mid_pix", pix, 8'hA0 + 8'(i));
        end
        g15_ce = 1'b1;
        cen = 1'b1;
        step();
        check("mid_pix4", pix, 8'hA4);
        check("mid_req", rom_if.rom_req, 1);
        reset_n = 1'b0;
        step();
        check("mrst_pix", pix, 0);
        check("mrst_req", rom_if.rom_req, 0);
        check("mrst_over", overrun, 0);
        check("mrst_addr", rom_if.rom_addr, 0);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_cen_addr", rom_if.rom_addr, 0);
        end
        cen = 1'b0;
        step();
        cen = 1'b1;
        step();
        check("post_rst_addr", rom_if.rom_addr, 1);

        // Randomized traffic.
        for (int i = 0; i < 4000; i++) begin
            reset_n  = ($urandom_range(0, 299) != 0);
            cen      = 1'($urandom_range(0, 1));
            pload_n  = ($urandom_range(0, 7) != 0);
            rl_sel   = ($urandom_range(0, 15) != 0) ? rl_sel : ~rl_sel;
            ab_sel   = ($urandom_range(0, 3) != 0) ? ab_sel : ~ab_sel;
            vdg      = ($urandom_range(0, 5) == 0);
            g15_ce   = ($urandom_range(0, 5) == 0);
            rom_if.rom_ack  = rom_if.rom_req ? ($urandom_range(0, 2) == 0)
                                             : ($urandom_range(0, 40) == 0);
            rom_if.rom_data = $urandom;
            rom_if.rom_attr = 4'($urandom);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
